// File: rtl/burst_accum_pkg.sv
// burst_accum_pkg: shared types and helpers for the burst accumulation engine.
//   state_t    : one-hot FSM encoding (IDLE, LOAD, PROCESS, DONE)
//   mode_t     : per-burst reduction mode (SUM, XOR, MAX, MIN; MAX/MIN unsigned)
//   acc_width(): per-lane result width, wide enough that a full-depth SUM
//                never overflows.
package burst_accum_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    LOAD    = 4'b0010,
    PROCESS = 4'b0100,
    DONE    = 4'b1000
  } state_t;

  typedef enum logic [1:0] {
    MODE_SUM = 2'b00,
    MODE_XOR = 2'b01,
    MODE_MAX = 2'b10,
    MODE_MIN = 2'b11
  } mode_t;

  function automatic int acc_width(input int width, input int depth);
    return width + $clog2(depth);
  endfunction

endpackage

// File: rtl/burst_accum_lane.sv
// burst_accum_lane: single-lane reducer.
//   clk    : clock
//   rst_i  : synchronous active-high reset (accumulator -> 0)
//   init_i : load the mode's identity value (0, or all ones for MIN)
//   en_i   : fold data_i into the accumulator
//   mode_i : reduction mode
//   data_i : lane sample, zero-extended to ACC_W
//   acc_o  : current accumulator value (held while neither init_i nor en_i)
module burst_accum_lane
  import burst_accum_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             init_i,
  input  logic             en_i,
  input  mode_t            mode_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [ACC_W-1:0] acc_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] ext;

  assign ext = {{(ACC_W-WIDTH){1'b0}}, data_i};

  always_comb begin
    acc_d = acc_q;
    if (init_i) begin
      acc_d = (mode_i == MODE_MIN) ? {ACC_W{1'b1}} : {ACC_W{1'b0}};
    end else if (en_i) begin
      case (mode_i)
        MODE_SUM: acc_d = acc_q + ext;
        MODE_XOR: acc_d = acc_q ^ ext;
        MODE_MAX: acc_d = (ext > acc_q) ? ext : acc_q;
        MODE_MIN: acc_d = (ext < acc_q) ? ext : acc_q;
        default:  acc_d = acc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/burst_accum_engine.sv
// burst_accum_engine: buffers a burst of 1..DEPTH beats of CHANNELS lanes,
// reduces every lane with the latched mode, and returns the per-lane results.
//   clk, rst          : clock, synchronous active-high reset
//   start, len, mode  : burst request (IDLE only), beat count, reduction mode
//   abort             : cancel the burst in progress (no effect in IDLE)
//   in_valid/in_ready : beat handshake, in_data lane k at [k*WIDTH +: WIDTH]
//   in_parity         : even parity per lane
//   out_valid/out_ready: result handshake, out_data lane k at [k*ACC_W +: ACC_W]
//   busy              : not IDLE
//   len_err           : one-cycle pulse after a start with len==0 or len>DEPTH
//   parity_err        : sticky lane-parity flag, cleared by an accepted start
// Build option: define BURST_ACCUM_PARITY_EN to enable parity checking;
// otherwise in_parity is ignored and parity_err is tied low.
module burst_accum_engine
  import burst_accum_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic [$clog2(DEPTH):0]                       len,
  input  logic [1:0]                                   mode,
  input  logic                                         abort,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [CHANNELS*WIDTH-1:0]                    in_data,
  input  logic [CHANNELS-1:0]                          in_parity,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [CHANNELS*acc_width(WIDTH, DEPTH)-1:0]  out_data,
  output logic                                         busy,
  output logic                                         len_err,
  output logic                                         parity_err
);

  localparam int ACC_W = acc_width(WIDTH, DEPTH);
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;

  state_t             state_q, state_d;
  logic [LW-1:0]      len_q, len_d;
  mode_t              mode_q, mode_d;
  logic [LW-1:0]      addr_q, addr_d;
  logic [LW-1:0]      cnt_q, cnt_d;
  logic               len_err_q;
  logic [CHANNELS*WIDTH-1:0] mem [DEPTH];
  logic [CHANNELS*WIDTH-1:0] rd_data_q;

  logic len_ok, start_acc, hs, rd_en, lane_init, lane_en;

  assign len_ok    = (len != '0) && (len <= LW'(DEPTH));
  assign start_acc = (state_q == IDLE) && start && len_ok;
  assign hs        = in_valid && in_ready;
  // PROCESS runs cnt_q = 0..len: reads issue for 0..len-1, and each read is
  // folded in one cycle later, so cnt_q==0 is free to seed the accumulators.
  assign rd_en     = (state_q == PROCESS) && (cnt_q < len_q);
  assign lane_init = (state_q == PROCESS) && (cnt_q == '0);
  assign lane_en   = (state_q == PROCESS) && (cnt_q != '0);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state (abort overrides every transition outside IDLE)
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_acc) state_d = LOAD;
      LOAD:    if (hs && (addr_q == len_q - LW'(1))) state_d = PROCESS;
      PROCESS: if (cnt_q == len_q) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == LOAD);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // Datapath registers
  always_comb begin
    len_d  = len_q;
    mode_d = mode_q;
    addr_d = addr_q;
    cnt_d  = '0;
    if (start_acc) begin
      len_d  = len;
      mode_d = mode_t'(mode);
      addr_d = '0;
    end else if (hs) begin
      addr_d = addr_q + LW'(1);
    end
    if (state_q == PROCESS) cnt_d = cnt_q + LW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      mode_q    <= MODE_SUM;
      addr_q    <= '0;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      len_q     <= len_d;
      mode_q    <= mode_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      len_err_q <= (state_q == IDLE) && start && !len_ok;
    end
  end

  assign len_err = len_err_q;

  // Burst buffer: not reset, registered read.
  always_ff @(posedge clk) begin
    if (hs)    mem[addr_q[AW-1:0]] <= in_data;
    if (rd_en) rd_data_q <= mem[cnt_q[AW-1:0]];
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      burst_accum_lane #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
      ) u_lane (
        .clk    (clk),
        .rst_i  (rst),
        .init_i (lane_init),
        .en_i   (lane_en),
        .mode_i (mode_q),
        .data_i (rd_data_q[gi*WIDTH +: WIDTH]),
        .acc_o  (out_data[gi*ACC_W +: ACC_W])
      );
    end
  endgenerate

`ifdef BURST_ACCUM_PARITY_EN
  logic [CHANNELS-1:0] lane_par_bad;
  logic                parity_err_q, parity_err_d;

  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_par
      assign lane_par_bad[gi] = ^{in_data[gi*WIDTH +: WIDTH], in_parity[gi]};
    end
  endgenerate

  always_comb begin
    parity_err_d = parity_err_q;
    if (start_acc)                 parity_err_d = 1'b0;
    else if (hs && |lane_par_bad)  parity_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`else
  logic unused_parity;
  assign unused_parity = ^in_parity;
  assign parity_err    = 1'b0;
`endif

endmodule

// File: tb/tb_burst_accum_engine.sv
module tb_burst_accum_engine;
  import burst_accum_pkg::*;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 16;
  localparam int CHANNELS = 4;
  localparam int LW       = 5;
  localparam int ACC_W    = 12;

  logic                      clk = 1'b0;
  logic                      rst, start, abort, in_valid, out_ready;
  logic [LW-1:0]             len;
  logic [1:0]                mode;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_parity;
  logic                      in_ready, out_valid, busy, len_err, parity_err;
  logic [CHANNELS*ACC_W-1:0] out_data;

  burst_accum_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .mode       (mode),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_parity  (in_parity),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .len_err    (len_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [CHANNELS*WIDTH-1:0] beats [DEPTH];
  logic [CHANNELS*ACC_W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CHANNELS-1:0] par(input logic [CHANNELS*WIDTH-1:0] d);
    logic [CHANNELS-1:0] p;
    for (int k = 0; k < CHANNELS; k++) p[k] = ^d[k*WIDTH +: WIDTH];
    return p;
  endfunction

  // Reference reduction over beats[0..n-1].
  function automatic logic [CHANNELS*ACC_W-1:0] model(input logic [1:0] md, input int n);
    logic [CHANNELS*ACC_W-1:0] r;
    logic [ACC_W-1:0] a, v;
    r = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      a = (md == 2'b11) ? {ACC_W{1'b1}} : {ACC_W{1'b0}};
      for (int i = 0; i < n; i++) begin
        v = {4'b0, beats[i][k*WIDTH +: WIDTH]};
        case (md)
          2'b00: a = a + v;
          2'b01: a = a ^ v;
          2'b10: if (v > a) a = v;
          default: if (v < a) a = v;
        endcase
      end
      r[k*ACC_W +: ACC_W] = a;
    end
    return r;
  endfunction

  task automatic run_burst(input int n, input logic [1:0] md, input int bp,
                           input bit start_mid, input int bad_beat);
    int cyc;
    logic [CHANNELS*ACC_W-1:0] e;
    exp_q.push_back(model(md, n));
    start = 1'b1; len = LW'(n); mode = md;
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("parity_clear_on_start", parity_err, 0);
    for (int i = 0; i < n; i++) begin
      in_valid  = 1'b1;
      in_data   = beats[i];
      in_parity = par(beats[i]);
      if (i == bad_beat) in_parity[2] = ~in_parity[2];
      if (start_mid && i == 1) begin start = 1'b1; len = LW'(1); end
      cyc = 0;
      while (!in_ready && cyc < 50) begin step(); cyc++; end
      if (cyc >= 50) check("in_ready_timeout", 0, 1);
      step();
      start = 1'b0;
    end
    in_valid  = 1'b0;
    in_parity = '0;
    cyc = 0;
    while (!out_valid && cyc < 200) begin step(); cyc++; end
    check("latency", cyc, n + 1);
    for (int b = 0; b < bp; b++) begin
      if (b == 0) begin in_valid = 1'b1; in_data = $urandom; end
      step();
      check("bp_in_ready", in_ready, 0);
      check("bp_out_data", out_data, exp_q[0]);
    end
    in_valid = 1'b0;
    e = exp_q.pop_front();
    check("result", out_data, e);
`ifdef BURST_ACCUM_PARITY_EN
    check("parity_err", parity_err, (bad_beat >= 0) ? 1 : 0);
`else
    check("parity_err", parity_err, 0);
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("idle_after_done", {out_valid, busy}, 0);
  endtask

  task automatic bad_len(input int l);
    start = 1'b1; len = LW'(l);
    step();
    start = 1'b0;
    check("len_err_pulse", {len_err, busy}, 2'b10);
    step();
    check("len_err_clear", {len_err, busy}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    len = '0; mode = 2'b00; in_data = '0; in_parity = '0;
    step(); step();
    check("rst_flags", {in_ready, out_valid, busy, len_err, parity_err}, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    step();

    // SUM, len 4: lane0 1..4, lane3 all 255.
    for (int i = 0; i < 4; i++) begin
      beats[i] = $urandom;
      beats[i][7:0]   = 8'(i + 1);
      beats[i][31:24] = 8'hFF;
    end
    run_burst(4, 2'b00, 0, 0, -1);

    // MAX then MIN on lane1 = 7, 200, 3.
    for (int i = 0; i < 3; i++) beats[i] = $urandom;
    beats[0][15:8] = 8'd7; beats[1][15:8] = 8'd200; beats[2][15:8] = 8'd3;
    run_burst(3, 2'b10, 0, 0, -1);
    run_burst(3, 2'b11, 0, 0, -1);

    // Full depth, with a stray start during LOAD.
    for (int i = 0; i < DEPTH; i++) beats[i] = $urandom;
    run_burst(DEPTH, 2'b00, 0, 1, -1);
    run_burst(DEPTH, 2'b01, 0, 0, -1);

    bad_len(0);
    bad_len(17);

    // Backpressure with a beat offered while in DONE.
    for (int i = 0; i < 5; i++) beats[i] = $urandom;
    run_burst(5, 2'b01, 10, 0, -1);
    run_burst(5, 2'b00, 0, 0, -1);

    // Abort in LOAD after 2 of 8 beats.
    for (int i = 0; i < 8; i++) beats[i] = $urandom;
    start = 1'b1; len = LW'(8); mode = 2'b00;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = beats[i]; in_parity = par(beats[i]);
      step();
    end
    in_valid = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_idle", {busy, in_ready}, 0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin step(); if (out_valid) seen = 1'b1; end
    check("abort_no_result", seen, 0);
    run_burst(8, 2'b11, 0, 0, -1);

    // Reset while in PROCESS.
    for (int i = 0; i < 6; i++) beats[i] = $urandom;
    start = 1'b1; len = LW'(6); mode = 2'b00;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = beats[i]; in_parity = par(beats[i]);
      step();
    end
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_idle", {busy, out_valid}, 0);
    check("rst_mid_out_data", out_data, 0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin step(); if (out_valid) seen = 1'b1; end
    check("rst_no_result", seen, 0);
    run_burst(6, 2'b00, 0, 0, -1);

    // Corrupted parity on lane 2 of beat 1; flag must persist until next start.
    for (int i = 0; i < 4; i++) beats[i] = $urandom;
    run_burst(4, 2'b00, 0, 0, 1);
    step(); step();
`ifdef BURST_ACCUM_PARITY_EN
    check("parity_held_idle", parity_err, 1);
`else
    check("parity_held_idle", parity_err, 0);
`endif
    run_burst(4, 2'b01, 0, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/burst_accum_engine.md
Name: burst_accum_engine

Overview:
- Multi-lane burst buffer and reducer; successor to the single-lane load/process/done controller.
- Accepts a burst of 1..DEPTH beats of CHANNELS lanes over a valid/ready stream and stores it in an internal buffer.
- Reduces each lane independently with a per-burst mode (sum, xor, max, min).
- Returns the per-lane results over a valid/ready output handshake.

Parameters:
- WIDTH, 8, bits per lane.
- DEPTH, 16, maximum beats per burst (power of two, >=2).
- CHANNELS, 4, number of independent lanes.
- ACC_W, WIDTH+$clog2(DEPTH), derived per-lane result width (localparam).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  burst request, sampled in IDLE only
- len  in  $clog2(DEPTH)+1  beat count for this burst
- mode  in  2  00 SUM, 01 XOR, 10 MAX (unsigned), 11 MIN (unsigned); latched at start
- abort  in  1  cancel current burst
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid&&in_ready
- in_data  in  CHANNELS*WIDTH  lane k at [k*WIDTH +: WIDTH]
- in_parity  in  CHANNELS  even parity per lane (see Optional Feature)
- out_valid  out  1  result valid
- out_ready  in  1  result taken
- out_data  out  CHANNELS*ACC_W  lane k at [k*ACC_W +: ACC_W]
- busy  out  1  state != IDLE
- len_err  out  1  one-cycle pulse on rejected start
- parity_err  out  1  sticky parity flag

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state IDLE; in_ready, out_valid, busy, len_err, parity_err = 0; out_data = 0; address and count registers = 0. Buffer contents are not reset.
- FSM states: IDLE, LOAD, PROCESS, DONE (one-hot, 4 bits).
- IDLE:
  - start with 1<=len<=DEPTH: latch len and mode, addr=0, clear parity_err, go to LOAD.
  - start with len==0 or len>DEPTH: len_err=1 for one cycle, stay in IDLE.
- LOAD:
  - in_ready=1.
  - On each handshake, write mem[addr] and increment addr.
  - The handshake with addr==len-1 moves to PROCESS.
  - Beats offered in other states are not accepted (in_ready=0).
- PROCESS:
  - Synchronous-read buffer with 1-cycle read latency; one read issued per cycle for idx 0..len-1.
  - Accumulate on the following cycle, so PROCESS lasts len+1 cycles.
  - Accumulator initial values: SUM/XOR/MAX = 0; MIN = all ones over ACC_W.
  - Lane data is zero-extended to ACC_W. SUM cannot overflow by construction of ACC_W.
- DONE:
  - out_valid=1; out_data is held stable until out_ready.
  - On handshake: out_valid=0, go to IDLE.
- Latency: out_valid rises exactly len+1 cycles after the clock edge that accepts the last beat.
- start is ignored while busy. A new start is accepted in IDLE on the cycle after the DONE handshake.
- abort has priority over all transitions:
  - Next state is IDLE; in_ready and out_valid drop; no result is delivered.
  - abort in IDLE has no effect.
- Simultaneous abort and out_ready in DONE: treated as abort (same end state).
- rst mid-burst returns to reset values on the next edge, regardless of handshakes in flight.
- addr never wraps, because len<=DEPTH is enforced at start.

Optional Feature:
- Macro: BURST_ACCUM_PARITY_EN.
- Defined:
  - Each accepted beat's lane k is checked: ^{in_data lane k, in_parity[k]} must be 0.
  - Any mismatch sets parity_err, which stays set until the next accepted start or rst.
  - Data is still stored and reduced normally.
- Undefined: in_parity is ignored and parity_err is tied to 0. The port list is unchanged.

Decomposition:
- Package burst_accum_pkg holds:
  - state encodings IDLE/LOAD/PROCESS/DONE;
  - mode encodings MODE_SUM/MODE_XOR/MODE_MAX/MODE_MIN;
  - a function computing ACC_W.
- One sub-module, burst_accum_lane: a single-lane accumulator (init, accumulate, mode), instantiated CHANNELS times via generate.
- The buffer stays inline as a CHANNELS*WIDTH-wide memory.

Test Plan:
- SUM, CHANNELS=4, len=4, lane0 beats 1,2,3,4 and lane3 beats 255×4 -> lane0=10, lane3=1020; out_valid exactly 5 cycles after the last accept.
- MAX/MIN, len=3, lane1 beats 7,200,3 -> MAX=200; MIN run gives 3; len=DEPTH=16 burst completes with no wrap.
- start with len=0 and with len=17 -> len_err pulses 1 cycle, busy stays 0; start asserted during LOAD is ignored.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0; a beat offered then is not consumed.
- abort in LOAD after 2 of 8 beats, and separately rst in PROCESS -> IDLE next cycle, out_valid never rises, next burst's result is correct.
- With BURST_ACCUM_PARITY_EN: corrupt in_parity[2] on beat 1 -> parity_err=1 and held until the next start; without the macro, parity_err stays 0.
